// File: rtl/cpu7_exc_ctl_pkg.sv
// Shared definitions for the cpu7 _e-stage exception controller: widths,
// ESTAT.Ecode values and the redirect FSM state type.
package cpu7_exc_ctl_pkg;

   localparam int GRLEN   = 32;
   localparam int ECODE_W = 6;

   localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
   localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
   localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
   localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
   localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
   localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_DRAIN = 2'd2
   } exc_state_e;

endpackage

// File: rtl/cpu7_exc_ctl_if.sv
// PC redirect channel from the exception controller (master) to the IFU (slave).
interface cpu7_exc_ctl_if;
   import cpu7_exc_ctl_pkg::*;

   logic             exu_ifu_redir_vld;
   logic [GRLEN-1:0] exu_ifu_redir_pc;
   logic             ifu_exu_redir_rdy;

   modport master (
      output exu_ifu_redir_vld,
      output exu_ifu_redir_pc,
      input  ifu_exu_redir_rdy
   );

   modport slave (
      input  exu_ifu_redir_vld,
      input  exu_ifu_redir_pc,
      output ifu_exu_redir_rdy
   );

endinterface

// File: rtl/cpu7_exc_prio.sv
// Fixed-priority encoder for _e-stage exception sources; the interrupt input
// must already be masked by the caller when interrupts are not allowed.
module cpu7_exc_prio
   import cpu7_exc_ctl_pkg::*;
(
   input  logic               intr,
   input  logic               adef,
   input  logic               ine,
   input  logic               sys,
   input  logic               brk,
   input  logic               ale,
   output logic               hit,
   output logic [ECODE_W-1:0] ecode
);

   always_comb begin
      hit   = 1'b1;
      ecode = '0;
      if (intr)      ecode = ECODE_INT;
      else if (adef) ecode = ECODE_ADEF;
      else if (ine)  ecode = ECODE_INE;
      else if (sys)  ecode = ECODE_SYS;
      else if (brk)  ecode = ECODE_BRK;
      else if (ale)  ecode = ECODE_ALE;
      else           hit   = 1'b0;
   end

endmodule

// File: rtl/cpu7_exc_ctl.sv
// _e-stage exception/interrupt arbiter: CSR strobes, squash and held PC redirect to IFU.
// Optional CPU7_EXC_PERF_EN adds exception/interrupt event counters.
module cpu7_exc_ctl
   import cpu7_exc_ctl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
)(
   input  logic               clk,
   input  logic               resetn,
   input  logic               ecl_valid_e,
   input  logic [GRLEN-1:0]   ifu_exu_pc_e,
   input  logic               ifu_exu_adef_e,
   input  logic               dec_exu_ine_e,
   input  logic               dec_exu_sys_e,
   input  logic               dec_exu_brk_e,
   input  logic               lsu_ecl_ale_e,
   input  logic               dec_exu_ertn_e,
   input  logic               csr_ecl_timer_intr,
   input  logic [GRLEN-1:0]   csr_eentry,
   input  logic [GRLEN-1:0]   csr_era,
   output logic               exu_ifu_except,
   output logic [ECODE_W-1:0] ecl_csr_exccode_e,
   output logic               ecl_csr_ertn_e,
   output logic               ecl_kill_e,
`ifdef CPU7_EXC_PERF_EN
   output logic [31:0]        ecl_perf_exc_cnt,
   output logic [31:0]        ecl_perf_int_cnt,
`endif
   cpu7_exc_ctl_if.master     redir_if
);

   exc_state_e       state, state_nxt;
   logic [2:0]       drain_cnt, drain_cnt_nxt;
   logic [GRLEN-1:0] redir_pc;
   logic             take_ok;
   logic             intr_ok;
   logic             prio_hit;
   logic [ECODE_W-1:0] prio_ecode;

   // The _e PC is carried for debug only; ERA capture lives in the CSR block.
   logic unused_pc;
   assign unused_pc = ^ifu_exu_pc_e;

   // Instructions are honoured unless a redirect is outstanding; the timer
   // interrupt is additionally held off while the pipeline drains after a redirect.
   assign take_ok = ecl_valid_e && (state != ST_REDIR);
   assign intr_ok = csr_ecl_timer_intr && (state == ST_IDLE);

   cpu7_exc_prio u_prio (
      .intr  (intr_ok),
      .adef  (ifu_exu_adef_e),
      .ine   (dec_exu_ine_e),
      .sys   (dec_exu_sys_e),
      .brk   (dec_exu_brk_e),
      .ale   (lsu_ecl_ale_e),
      .hit   (prio_hit),
      .ecode (prio_ecode)
   );

   always_comb begin
      exu_ifu_except    = take_ok && prio_hit;
      ecl_csr_ertn_e    = take_ok && dec_exu_ertn_e && !prio_hit;
      ecl_csr_exccode_e = exu_ifu_except ? prio_ecode : '0;
      ecl_kill_e        = exu_ifu_except || ecl_csr_ertn_e || (state == ST_REDIR);
   end

   assign redir_if.exu_ifu_redir_vld = (state == ST_REDIR);
   assign redir_if.exu_ifu_redir_pc  = redir_pc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // A new event in DRAIN restarts the redirect; otherwise the countdown runs out to IDLE.
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      unique case (state)
         ST_IDLE: begin
            if (exu_ifu_except || ecl_csr_ertn_e) state_nxt = ST_REDIR;
         end
         ST_REDIR: begin
            if (redir_if.ifu_exu_redir_rdy) begin
               state_nxt     = ST_DRAIN;
               drain_cnt_nxt = 3'(DRAIN_CYCLES - 1);
            end
         end
         ST_DRAIN: begin
            if (exu_ifu_except || ecl_csr_ertn_e) begin
               state_nxt     = ST_REDIR;
               drain_cnt_nxt = '0;
            end else if (drain_cnt == 3'd0) begin
               state_nxt = ST_IDLE;
            end else begin
               drain_cnt_nxt = drain_cnt - 3'd1;
            end
         end
         default: begin
            state_nxt     = ST_IDLE;
            drain_cnt_nxt = '0;
         end
      endcase
   end

   // csr_era is sampled before the CSR block overwrites it on this same edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redir_pc <= '0;
      end else if (exu_ifu_except || ecl_csr_ertn_e) begin
         redir_pc <= exu_ifu_except ? csr_eentry : csr_era;
      end
   end

`ifdef CPU7_EXC_PERF_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ecl_perf_exc_cnt <= '0;
         ecl_perf_int_cnt <= '0;
      end else if (exu_ifu_except) begin
         if (ecl_csr_exccode_e == ECODE_INT) ecl_perf_int_cnt <= ecl_perf_int_cnt + 32'd1;
         else                                ecl_perf_exc_cnt <= ecl_perf_exc_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu7_exc_ctl.sv
// Bench for cpu7_exc_ctl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_cpu7_exc_ctl;
   import cpu7_exc_ctl_pkg::*;

   localparam int DRAIN = 2;

   typedef struct packed {
      logic        valid, adef, ine, sys, brk, ale, ertn, intr, rdy;
      logic [31:0] pc, eentry, era;
   } stim_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ecl_valid_e, adef, ine, sys, brk, ale, ertn, intr;
   logic [31:0] pc_e, eentry, era;
   logic        except, ertn_strobe, kill;
   logic [5:0]  exccode;
`ifdef CPU7_EXC_PERF_EN
   logic [31:0] perf_exc, perf_int;
`endif

   cpu7_exc_ctl_if redir_if();

   cpu7_exc_ctl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .ecl_valid_e        (ecl_valid_e),
      .ifu_exu_pc_e       (pc_e),
      .ifu_exu_adef_e     (adef),
      .dec_exu_ine_e      (ine),
      .dec_exu_sys_e      (sys),
      .dec_exu_brk_e      (brk),
      .lsu_ecl_ale_e      (ale),
      .dec_exu_ertn_e     (ertn),
      .csr_ecl_timer_intr (intr),
      .csr_eentry         (eentry),
      .csr_era            (era),
      .exu_ifu_except     (except),
      .ecl_csr_exccode_e  (exccode),
      .ecl_csr_ertn_e     (ertn_strobe),
      .ecl_kill_e         (kill),
`ifdef CPU7_EXC_PERF_EN
      .ecl_perf_exc_cnt   (perf_exc),
      .ecl_perf_int_cnt   (perf_int),
`endif
      .redir_if           (redir_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: an outstanding redirect, its target, and how many more cycles interrupts stay masked.
   bit          m_busy;
   logic [31:0] m_tgt;
   int          m_quiet;
   bit          e_except, e_ertn, e_kill, e_vld;
   logic [5:0]  e_code;

   // DUT outputs captured at the compare point of the latest cycle.
   logic        d_except, d_ertn, d_kill, d_vld;
   logic [5:0]  d_code;
   logic [31:0] d_pc;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelEval(input stim_t st);
      bit         conds[6];
      logic [5:0] codes[6];
      codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
      conds = '{st.intr && (m_quiet == 0), st.adef, st.ine, st.sys, st.brk, st.ale};
      e_except = 0; e_ertn = 0; e_code = 0;
      if (m_busy) begin
         e_kill = 1;
         e_vld  = 1;
      end else begin
         e_vld = 0;
         if (st.valid) begin
            for (int i = 5; i >= 0; i--)
               if (conds[i]) begin e_except = 1; e_code = codes[i]; end
            e_ertn = st.ertn && !e_except;
         end
         e_kill = e_except || e_ertn;
      end
   endfunction

   function automatic void modelStep(input stim_t st);
      if (m_busy) begin
         if (st.rdy) begin m_busy = 0; m_quiet = DRAIN; end
      end else if (e_except || e_ertn) begin
         m_busy  = 1;
         m_tgt   = e_except ? st.eentry : st.era;
         m_quiet = 0;
      end else if (m_quiet > 0) begin
         m_quiet--;
      end
   endfunction

   function automatic void modelReset();
      m_busy = 0; m_tgt = 0; m_quiet = 0;
   endfunction

   task automatic driveInputs(input stim_t st);
      ecl_valid_e = st.valid; adef = st.adef; ine = st.ine; sys = st.sys;
      brk = st.brk; ale = st.ale; ertn = st.ertn; intr = st.intr;
      redir_if.ifu_exu_redir_rdy = st.rdy;
      pc_e = st.pc; eentry = st.eentry; era = st.era;
   endtask

   // One cycle: drive on the falling edge, compare 1ns later, advance the model on the rising edge.
   task automatic applyStimulus(input stim_t st);
      @(negedge clk);
      driveInputs(st);
      #1;
      modelEval(st);
      d_except = except; d_ertn = ertn_strobe; d_kill = kill; d_code = exccode;
      d_vld = redir_if.exu_ifu_redir_vld; d_pc = redir_if.exu_ifu_redir_pc;
      checkOutput("except", 32'(d_except), 32'(e_except));
      checkOutput("ertn_strobe", 32'(d_ertn), 32'(e_ertn));
      checkOutput("kill", 32'(d_kill), 32'(e_kill));
      checkOutput("redir_vld", 32'(d_vld), 32'(e_vld));
      if (e_except) checkOutput("exccode", 32'(d_code), 32'(e_code));
      if (e_vld)    checkOutput("redir_pc", d_pc, m_tgt);
      @(posedge clk);
      modelStep(st);
   endtask

   function automatic stim_t quiet(input bit rdy);
      stim_t st = '0;
      st.rdy = rdy; st.eentry = 32'h1C008000; st.era = 32'hDEAD0000;
      return st;
   endfunction

   function automatic stim_t randStim();
      stim_t st;
      st.valid  = ($urandom_range(0, 9) < 7);
      st.adef   = ($urandom_range(0, 9) == 0);
      st.ine    = ($urandom_range(0, 9) == 0);
      st.sys    = ($urandom_range(0, 9) == 0);
      st.brk    = ($urandom_range(0, 9) == 0);
      st.ale    = ($urandom_range(0, 9) == 0);
      st.ertn   = ($urandom_range(0, 5) == 0);
      st.intr   = ($urandom_range(0, 4) == 0);
      st.rdy    = $urandom_range(0, 1) == 1;
      st.pc     = $urandom;
      st.eentry = $urandom;
      st.era    = $urandom;
      return st;
   endfunction

   initial begin
      stim_t st;
      modelReset();
      resetn = 1'b0;
      driveInputs(quiet(0));
      #12;
      checkOutput("reset_except", 32'(except), 0);
      checkOutput("reset_kill", 32'(kill), 0);
      checkOutput("reset_vld", 32'(redir_if.exu_ifu_redir_vld), 0);
      checkOutput("reset_pc", redir_if.exu_ifu_redir_pc, 0);
      @(negedge clk);
      resetn = 1'b1;

      // ALE alone, then the redirect appears with SYS ignored while it is pending.
      st = quiet(0); st.valid = 1; st.ale = 1; st.pc = 32'h1C000010;
      applyStimulus(st);
      checkOutput("ale_except", 32'(d_except), 1);
      checkOutput("ale_code", 32'(d_code), 32'h09);
      st = quiet(0); st.valid = 1; st.sys = 1;
      applyStimulus(st);
      checkOutput("ale_vld", 32'(d_vld), 1);
      checkOutput("ale_pc", d_pc, 32'h1C008000);
      checkOutput("sys_in_redir", 32'(d_except), 0);
      applyStimulus(quiet(1));

      // Timer interrupt masked for both drain cycles, taken over ertn afterwards.
      st = quiet(0); st.valid = 1; st.intr = 1;
      applyStimulus(st);
      checkOutput("drain1_intr", 32'(d_except), 0);
      applyStimulus(st);
      checkOutput("drain2_intr", 32'(d_except), 0);
      checkOutput("drain2_kill", 32'(d_kill), 0);
      st.ertn = 1;
      applyStimulus(st);
      checkOutput("int_except", 32'(d_except), 1);
      checkOutput("int_code", 32'(d_code), 32'h00);
      checkOutput("int_no_ertn", 32'(d_ertn), 0);
      applyStimulus(quiet(1));

      // BRK in drain is taken; then stacked faults pick ADEF.
      st = quiet(0); st.valid = 1; st.brk = 1;
      applyStimulus(st);
      checkOutput("brk_code", 32'(d_code), 32'h0C);
      applyStimulus(quiet(1));
      st = quiet(0); st.valid = 1; st.adef = 1; st.ine = 1; st.ale = 1;
      applyStimulus(st);
      checkOutput("multi_code", 32'(d_code), 32'h08);
      applyStimulus(quiet(1));
      applyStimulus(quiet(0));
      applyStimulus(quiet(0));

      // ertn to ERA, held three cycles without acceptance while ERA moves.
      st = quiet(0); st.valid = 1; st.ertn = 1; st.era = 32'h1C000100;
      applyStimulus(st);
      checkOutput("ertn_strobe_lit", 32'(d_ertn), 1);
      for (int i = 0; i < 3; i++) begin
         st = quiet(0); st.era = 32'h1C000200 + 32'(i);
         applyStimulus(st);
         checkOutput("hold_vld", 32'(d_vld), 1);
         checkOutput("hold_pc", d_pc, 32'h1C000100);
         checkOutput("hold_kill", 32'(d_kill), 1);
      end

      // Reset mid-redirect drops the request at once and leaves nothing pending.
      @(negedge clk);
      driveInputs(quiet(0));
      #2;
      resetn = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_vld", 32'(redir_if.exu_ifu_redir_vld), 0);
      checkOutput("rst_kill", 32'(kill), 0);
      checkOutput("rst_pc", redir_if.exu_ifu_redir_pc, 0);
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(quiet(0));
      checkOutput("post_rst_vld", 32'(d_vld), 0);

      for (int n = 0; n < 3000; n++) applyStimulus(randStim());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
